// File: rtl/wb_bram_port_ctrl.sv
// Wishbone B4 pipelined slave driving one port of a registered-output BRAM, with byte-select RMW writes.
// Optional macro WB_BRAM_PORT_ERR_EN: out-of-range addresses terminate with o_wb_err instead of aliasing.
module wb_bram_port_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int MEM_WORDS  = 1024
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_wb_cyc,
    input  logic                      i_wb_stb,
    input  logic                      i_wb_we,
    input  logic [ADDR_WIDTH-1:0]     i_wb_addr,
    input  logic [DATA_WIDTH-1:0]     i_wb_data,
    input  logic [DATA_WIDTH/8-1:0]   i_wb_sel,
    output logic                      o_wb_stall,
    output logic                      o_wb_ack,
    output logic [DATA_WIDTH-1:0]     o_wb_data,
    output logic                      o_wb_err,
    output logic                      o_mem_en,
    output logic                      o_mem_we,
    output logic [ADDR_WIDTH-1:0]     o_mem_addr,
    output logic [DATA_WIDTH-1:0]     o_mem_din,
    input  logic [DATA_WIDTH-1:0]     i_mem_dout
);

    localparam int SEL_WIDTH = DATA_WIDTH / 8;
    localparam int AW1       = ADDR_WIDTH + 1;

    if ((DATA_WIDTH % 8) != 0 || MEM_WORDS > (1 << ADDR_WIDTH)) begin : g_bad_cfg
        $error("wb_bram_port_ctrl: DATA_WIDTH must be a multiple of 8 and MEM_WORDS <= 2**ADDR_WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RMW_RD   = 2'd1,
        RMW_WAIT = 2'd2,
        RMW_WR   = 2'd3
    } state_t;

    state_t                 state;
    logic                   accept;
    logic                   full_sel;
    logic                   zero_sel;
    logic                   range_err;
    logic                   rmw_done;
    logic                   vld_p0;
    logic                   vld_p1;
    logic [DATA_WIDTH-1:0]  wdata_p0;
    logic [SEL_WIDTH-1:0]   sel_p0;

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] wr_word,
        input logic [DATA_WIDTH-1:0] rd_word,
        input logic [SEL_WIDTH-1:0]  sel
    );
        logic [DATA_WIDTH-1:0] merged;
        merged = rd_word;
        for (int b = 0; b < SEL_WIDTH; b++) begin
            if (sel[b]) merged[8*b +: 8] = wr_word[8*b +: 8];
        end
        return merged;
    endfunction

    assign accept   = i_wb_cyc && i_wb_stb && !o_wb_stall;
    assign full_sel = &i_wb_sel;
    assign zero_sel = ~|i_wb_sel;
    assign rmw_done = (state == RMW_WR);

`ifdef WB_BRAM_PORT_ERR_EN
    localparam logic [ADDR_WIDTH:0] MEM_LIMIT = AW1'(MEM_WORDS);

    logic err_p0;
    logic err_p1;

    assign range_err = ({1'b0, i_wb_addr} >= MEM_LIMIT);

    // Error path mirrors the ack pipeline so err lands with full-word latency.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            err_p0   <= 1'b0;
            err_p1   <= 1'b0;
            o_wb_err <= 1'b0;
        end else begin
            err_p0   <= accept && range_err;
            err_p1   <= err_p0 && i_wb_cyc;
            o_wb_err <= err_p1 && i_wb_cyc;
        end
    end
`else
    assign range_err = 1'b0;
    assign o_wb_err  = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= IDLE;
            o_wb_stall <= 1'b0;
            o_wb_ack   <= 1'b0;
            o_wb_data  <= '0;
            o_mem_en   <= 1'b0;
            o_mem_we   <= 1'b0;
            o_mem_addr <= '0;
            o_mem_din  <= '0;
            vld_p0     <= 1'b0;
            vld_p1     <= 1'b0;
        end else begin
            // p1 -> p2: BRAM dout is valid now; capture it and raise the ack.
            vld_p1   <= vld_p0 && i_wb_cyc;
            o_wb_ack <= (vld_p1 || rmw_done) && i_wb_cyc;
            if (vld_p1) o_wb_data <= i_mem_dout;

            // p0: default to an idle port; each state below may claim it.
            vld_p0   <= 1'b0;
            o_mem_en <= 1'b0;
            o_mem_we <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept) begin
                        o_mem_addr <= i_wb_addr;
                        o_mem_din  <= i_wb_data;
                        wdata_p0   <= i_wb_data;
                        sel_p0     <= i_wb_sel;
                        if (!range_err) begin
                            if (!i_wb_we || full_sel) begin
                                o_mem_en <= 1'b1;
                                o_mem_we <= i_wb_we;
                                vld_p0   <= 1'b1;
                            end else if (zero_sel) begin
                                vld_p0   <= 1'b1;
                            end else begin
                                o_mem_en   <= 1'b1;
                                o_wb_stall <= 1'b1;
                                state      <= RMW_RD;
                            end
                        end
                    end
                end
                RMW_RD: begin
                    if (!i_wb_cyc) begin
                        o_wb_stall <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        state      <= RMW_WAIT;
                    end
                end
                RMW_WAIT: begin
                    if (!i_wb_cyc) begin
                        o_wb_stall <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        o_mem_en  <= 1'b1;
                        o_mem_we  <= 1'b1;
                        o_mem_din <= merge_bytes(wdata_p0, i_mem_dout, sel_p0);
                        state     <= RMW_WR;
                    end
                end
                RMW_WR: begin
                    o_wb_stall <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    o_wb_stall <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_bram_port_ctrl.sv
// Directed self-checking bench for wb_bram_port_ctrl with a registered-output BRAM model.
module tb_wb_bram_port_ctrl;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int SW = DW / 8;
    localparam int MW = 512;

    logic          clk = 1'b0;
    logic          rst;
    logic          cyc, stb, we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] sel;
    logic          stall, ack, err;
    logic [DW-1:0] rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    int n_checks = 0;
    int n_fail   = 0;
    int en_cnt   = 0;
    int we_cnt   = 0;

    logic [DW-1:0] b2b_val [4] = '{32'h01020304, 32'h55AA55AA, 32'h00000000, 32'hFFFFFFFF};

    always #5 clk = ~clk;

    wb_bram_port_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .MEM_WORDS  (MW)
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_wb_cyc   (cyc),
        .i_wb_stb   (stb),
        .i_wb_we    (we),
        .i_wb_addr  (addr),
        .i_wb_data  (wdata),
        .i_wb_sel   (sel),
        .o_wb_stall (stall),
        .o_wb_ack   (ack),
        .o_wb_data  (rdata),
        .o_wb_err   (err),
        .o_mem_en   (mem_en),
        .o_mem_we   (mem_we),
        .o_mem_addr (mem_addr),
        .o_mem_din  (mem_din),
        .i_mem_dout (mem_dout)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_din;
            mem_dout <= mem[mem_addr];
        end
        if (mem_en) en_cnt <= en_cnt + 1;
        if (mem_we) we_cnt <= we_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request, then wait (bounded) for its ack/err and check latency.
    task automatic xfer(input string tag, input logic we_i, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [SW-1:0] s,
                        input int exp_lat, input logic exp_err, output logic [DW-1:0] rd);
        int lat;
        check_eq({tag, "_stall"}, stall, 1'b0);
        cyc = 1'b1; stb = 1'b1; we = we_i; addr = a; wdata = d; sel = s;
        tick();
        stb = 1'b0; we = 1'b0;
        lat = 1;
        while (!ack && !err && lat < 12) begin
            tick();
            lat++;
        end
        check_eq({tag, "_lat"}, lat, exp_lat);
        check_eq({tag, "_ack"}, ack, !exp_err);
        check_eq({tag, "_err"}, err, exp_err);
        rd = rdata;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ack"},   ack,      1'b0);
        check_eq({tag, "_err"},   err,      1'b0);
        check_eq({tag, "_stall"}, stall,    1'b0);
        check_eq({tag, "_en"},    mem_en,   1'b0);
        check_eq({tag, "_we"},    mem_we,   1'b0);
        check_eq({tag, "_addr"},  mem_addr, '0);
        check_eq({tag, "_din"},   mem_din,  '0);
        check_eq({tag, "_data"},  rdata,    '0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] rd;
        int saved_en;
        int saved_we;

        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; wdata = '0; sel = '0;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Full-word write then read back.
        xfer("fw_wr", 1'b1, 10'h005, 32'hDEADBEEF, 4'hF, 3, 1'b0, rd);
        xfer("fw_rd", 1'b0, 10'h005, 32'h0, 4'hF, 3, 1'b0, rd);
        check_eq("fw_rd_data", rd, 32'hDEADBEEF);

        // Back-to-back reads after preloading four words.
        for (int i = 0; i < 4; i++)
            xfer($sformatf("b2b_pre%0d", i), 1'b1, AW'(16 + i), b2b_val[i], 4'hF, 3, 1'b0, rd);
        tick(); tick();
        for (int c = 0; c < 9; c++) begin
            if (c < 4) begin
                cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = AW'(16 + c);
            end else begin
                stb = 1'b0;
            end
            check_eq($sformatf("b2b_stall%0d", c), stall, 1'b0);
            if (c >= 3 && c <= 6) begin
                check_eq($sformatf("b2b_ack%0d", c), ack, 1'b1);
                check_eq($sformatf("b2b_data%0d", c), rdata, b2b_val[c-3]);
            end else begin
                check_eq($sformatf("b2b_ack%0d", c), ack, 1'b0);
            end
            tick();
        end

        // Partial write: stall for 3 cycles, ack at N+4, merged result.
        xfer("pw_pre", 1'b1, 10'h020, 32'h11223344, 4'hF, 3, 1'b0, rd);
        saved_we = we_cnt;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 10'h020; wdata = 32'hAABBCCDD; sel = 4'b0101;
        check_eq("pw_acc_stall", stall, 1'b0);
        tick();
        stb = 1'b0; we = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            check_eq($sformatf("pw_stall_n%0d", c), stall, 1'b1);
            check_eq($sformatf("pw_ack_n%0d", c), ack, 1'b0);
            tick();
        end
        check_eq("pw_stall_n4", stall, 1'b0);
        check_eq("pw_ack_n4", ack, 1'b1);
        check_eq("pw_we_count", we_cnt - saved_we, 1);
        tick();
        xfer("pw_rd", 1'b0, 10'h020, 32'h0, 4'hF, 3, 1'b0, rd);
        check_eq("pw_rd_data", rd, 32'h11BB33DD);

        // sel == 0 write: acked, no memory access.
        xfer("s0_pre", 1'b1, 10'h030, 32'h12345678, 4'hF, 3, 1'b0, rd);
        saved_en = en_cnt;
        xfer("s0_wr", 1'b1, 10'h030, 32'hFFFFFFFF, 4'h0, 3, 1'b0, rd);
        check_eq("s0_no_en", en_cnt - saved_en, 0);
        xfer("s0_rd", 1'b0, 10'h030, 32'h0, 4'hF, 3, 1'b0, rd);
        check_eq("s0_rd_data", rd, 32'h12345678);

        // Abort in RMW_RD: no write, no ack, word unchanged.
        xfer("ab_pre", 1'b1, 10'h040, 32'hCAFEF00D, 4'hF, 3, 1'b0, rd);
        tick();
        saved_we = we_cnt;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 10'h040; wdata = 32'h0; sel = 4'b0011;
        check_eq("ab_acc_stall", stall, 1'b0);
        tick();
        stb = 1'b0; we = 1'b0;
        check_eq("ab_rmw_stall", stall, 1'b1);
        cyc = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            check_eq($sformatf("ab_ack%0d", c), ack, 1'b0);
            check_eq($sformatf("ab_mem_we%0d", c), mem_we, 1'b0);
        end
        check_eq("ab_stall_idle", stall, 1'b0);
        check_eq("ab_we_count", we_cnt - saved_we, 0);
        cyc = 1'b1;
        tick();
        xfer("ab_rd", 1'b0, 10'h040, 32'h0, 4'hF, 3, 1'b0, rd);
        check_eq("ab_rd_data", rd, 32'hCAFEF00D);

        // Reset mid-stream: read in flight plus an RMW on the port.
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 10'h005; sel = 4'hF;
        check_eq("rm_acc0_stall", stall, 1'b0);
        tick();
        we = 1'b1; addr = 10'h005; wdata = 32'h000000FF; sel = 4'b0001;
        check_eq("rm_acc1_stall", stall, 1'b0);
        tick();
        stb = 1'b0; we = 1'b0;
        check_eq("rm_rmw_stall", stall, 1'b1);
        check_eq("rm_rmw_en", mem_en, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("rm_after");
        for (int c = 0; c < 4; c++) begin
            tick();
            check_eq($sformatf("rm_ack%0d", c), ack, 1'b0);
        end
        xfer("rm_rd", 1'b0, 10'h005, 32'h0, 4'hF, 3, 1'b0, rd);
        check_eq("rm_rd_data", rd, 32'hDEADBEEF);

`ifdef WB_BRAM_PORT_ERR_EN
        // Out-of-range requests terminate with err and never touch the port.
        saved_en = en_cnt;
        xfer("err_rd", 1'b0, 10'h200, 32'h0, 4'hF, 3, 1'b1, rd);
        check_eq("err_rd_no_en", en_cnt - saved_en, 0);
        saved_en = en_cnt;
        xfer("err_pw", 1'b1, 10'h201, 32'h12345678, 4'b0011, 3, 1'b1, rd);
        check_eq("err_pw_no_en", en_cnt - saved_en, 0);
`endif

        tick(); tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
